// File: rtl/lime_pkg.sv
// lime_pkg: shared widths, opcode constants and instruction field positions for the 16-bit core.
package lime_pkg;
    localparam int XLEN    = 16;
    localparam int RADDR_W = 3;
    localparam logic [XLEN-1:0] RESET_INSTR = 16'h0003;
    localparam logic [2:0] OP_3R  = 3'b000;
    localparam logic [2:0] OP_2RI = 3'b001;
    localparam logic [2:0] OP_RI  = 3'b010;
    localparam logic [2:0] OP_L   = 3'b011;
    localparam logic [2:0] OP_UJ  = 3'b100;
    localparam int OPC_LSB   = 0;
    localparam int FUNCT_LSB = 3;
    localparam int RD_LSB    = 7;
    localparam int RS1_LSB   = 10;
    localparam int RS2_LSB   = 13;
    localparam int CW_W      = 7;
    // Every opcode above OP_UJ is unassigned.
    function automatic logic is_illegal(input logic [2:0] op);
        return op > OP_UJ;
    endfunction
endpackage

// File: rtl/ir_decode_if.sv
// ir_decode_if: memory-side inputs and decoded outputs of ir_decode; instr_count exists only with IR_DECODE_PERF_EN.
interface ir_decode_if;
    import lime_pkg::*;
    logic                IRWrite;
    logic                MemR;
    logic [XLEN-1:0]     mem_rdata;
    logic [CW_W-1:0]     control_word;
    logic [RADDR_W-1:0]  rd_addr;
    logic [RADDR_W-1:0]  rs1_addr;
    logic [RADDR_W-1:0]  rs2_addr;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     mdr;
    logic                ir_valid;
    logic                illegal_op;
`ifdef IR_DECODE_PERF_EN
    logic [15:0]         instr_count;
    modport master (output IRWrite, MemR, mem_rdata,
                    input control_word, rd_addr, rs1_addr, rs2_addr, imm_ext, mdr, ir_valid, illegal_op, instr_count);
    modport slave  (input IRWrite, MemR, mem_rdata,
                    output control_word, rd_addr, rs1_addr, rs2_addr, imm_ext, mdr, ir_valid, illegal_op, instr_count);
`else
    modport master (output IRWrite, MemR, mem_rdata,
                    input control_word, rd_addr, rs1_addr, rs2_addr, imm_ext, mdr, ir_valid, illegal_op);
    modport slave  (input IRWrite, MemR, mem_rdata,
                    output control_word, rd_addr, rs1_addr, rs2_addr, imm_ext, mdr, ir_valid, illegal_op);
`endif
endinterface

// File: rtl/ir_decode_imm_gen.sv
// imm_gen: combinational sign-extended immediate from opcode and IR[15:7].
module imm_gen
    import lime_pkg::*;
(
    input  logic [2:0]      opcode_i,
    input  logic [8:0]      field_i,
    output logic [XLEN-1:0] imm_o
);
    // field_i[8] is IR[15], the MSB of every immediate format.
    always_comb begin
        imm_o = (opcode_i == OP_2RI) ? {{13{field_i[8]}}, field_i[8:6]} :
                (opcode_i == OP_RI || opcode_i == OP_L) ? {{10{field_i[8]}}, field_i[8:3]} :
                (opcode_i == OP_UJ) ? {{7{field_i[8]}}, field_i} : '0;
    end
endmodule

// File: rtl/ir_decode.sv
// ir_decode: instruction and memory data registers with field/immediate decode.
// Defining IR_DECODE_PERF_EN adds a wrapping 16-bit instr_count of IRWrite edges.
module ir_decode
    import lime_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    ir_decode_if.slave bus
);
    logic [XLEN-1:0] ir_q, ir_d, mdr_q, mdr_d;
    logic            valid_q, valid_d, illegal_q, illegal_d;
`ifdef IR_DECODE_PERF_EN
    logic [15:0]     count_q, count_d;
`endif
    always_comb begin
        ir_d      = bus.IRWrite ? bus.mem_rdata : ir_q;
        mdr_d     = bus.MemR ? bus.mem_rdata : mdr_q;
        valid_d   = valid_q | bus.IRWrite;
        illegal_d = illegal_q | (bus.IRWrite & is_illegal(bus.mem_rdata[2:0]));
`ifdef IR_DECODE_PERF_EN
        count_d   = bus.IRWrite ? count_q + 16'd1 : count_q;
`endif
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ir_q      <= RESET_INSTR;
            mdr_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef IR_DECODE_PERF_EN
            count_q   <= '0;
`endif
        end else begin
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
`ifdef IR_DECODE_PERF_EN
            count_q   <= count_d;
`endif
        end
    end
    assign bus.control_word = ir_q[FUNCT_LSB+3:OPC_LSB];
    assign bus.rd_addr      = ir_q[RD_LSB +: RADDR_W];
    assign bus.rs1_addr     = ir_q[RS1_LSB +: RADDR_W];
    assign bus.rs2_addr     = ir_q[RS2_LSB +: RADDR_W];
    assign bus.mdr          = mdr_q;
    assign bus.ir_valid     = valid_q;
    assign bus.illegal_op   = illegal_q;
`ifdef IR_DECODE_PERF_EN
    assign bus.instr_count  = count_q;
`endif
    imm_gen u_imm_gen (
        .opcode_i (ir_q[2:0]),
        .field_i  (ir_q[15:7]),
        .imm_o    (bus.imm_ext)
    );
endmodule

// File: tb/tb_ir_decode.sv
// tb_ir_decode: random and directed stimulus checked against a behavioural IR/MDR model.
module tb_ir_decode;
    import lime_pkg::*;
    logic CLK = 1'b0;
    logic Reset;
    ir_decode_if bus();
    ir_decode dut (.CLK(CLK), .Reset(Reset), .bus(bus));
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_ir, m_mdr, m_cnt;
    logic        m_valid, m_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_imm(input logic [15:0] ir);
        logic signed [15:0] s;
        s = $signed(ir);
        case (ir % 8)
            1:       return 16'(s >>> 13);
            2, 3:    return 16'(s >>> 10);
            4:       return 16'(s >>> 7);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cw"},    32'(bus.control_word), 32'(m_ir % 128));
        chk({tag, ".rd"},    32'(bus.rd_addr),      32'((m_ir >> 7) % 8));
        chk({tag, ".rs1"},   32'(bus.rs1_addr),     32'((m_ir >> 10) % 8));
        chk({tag, ".rs2"},   32'(bus.rs2_addr),     32'(m_ir >> 13));
        chk({tag, ".imm"},   32'(bus.imm_ext),      32'(exp_imm(m_ir)));
        chk({tag, ".mdr"},   32'(bus.mdr),          32'(m_mdr));
        chk({tag, ".valid"}, 32'(bus.ir_valid),     32'(m_valid));
        chk({tag, ".ill"},   32'(bus.illegal_op),   32'(m_ill));
`ifdef IR_DECODE_PERF_EN
        chk({tag, ".cnt"},   32'(bus.instr_count),  32'(m_cnt));
`endif
    endtask

    // Called just after a falling edge; asserts Reset mid-cycle.
    task automatic do_reset(input string tag);
        bus.IRWrite = 1'b0;
        bus.MemR = 1'b0;
        #2 Reset = 1'b1;
        m_ir = 16'h0003; m_mdr = 16'h0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = 16'h0;
        #1 check_all(tag);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic step(input string tag, input logic irw, input logic mr, input logic [15:0] d);
        bus.IRWrite = irw;
        bus.MemR = mr;
        bus.mem_rdata = d;
        @(posedge CLK);
        if (irw) begin
            if (d % 8 > 4) m_ill = 1'b1;
            m_ir = d;
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
        end
        if (mr) m_mdr = d;
        #1 check_all(tag);
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        bus.IRWrite = 1'b0;
        bus.MemR = 1'b0;
        bus.mem_rdata = 16'h0;
        @(negedge CLK);
        do_reset("init");
        step("abcd", 1'b1, 1'b0, 16'hABCD);
        chk("abcd_ill", 32'(bus.illegal_op), 32'd1);
        do_reset("midrst");
        chk("rst_cw", 32'(bus.control_word), 32'h03);
        step("e489", 1'b1, 1'b0, 16'hE489);
        chk("e489_cw", 32'(bus.control_word), 32'h09);
        chk("e489_rd", 32'(bus.rd_addr), 32'd1);
        chk("e489_rs1", 32'(bus.rs1_addr), 32'd1);
        chk("e489_rs2", 32'(bus.rs2_addr), 32'd7);
        chk("e489_imm", 32'(bus.imm_ext), 32'hFFFF);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 16'($urandom));
        chk("hold_imm", 32'(bus.imm_ext), 32'hFFFF);
        step("ri", 1'b1, 1'b0, 16'h8002);
        chk("ri_imm", 32'(bus.imm_ext), 32'hFFE0);
        step("uj", 1'b1, 1'b0, 16'h7F84);
        chk("uj_imm", 32'(bus.imm_ext), 32'h00FF);
        step("mdr1", 1'b0, 1'b1, 16'h1234);
        step("mdr2", 1'b0, 1'b0, 16'h5555);
        chk("mdr_val", 32'(bus.mdr), 32'h1234);
        chk("mdr_ir", 32'(bus.control_word), 32'h04);
        step("both", 1'b1, 1'b1, 16'h2C4A);
        step("ill6", 1'b1, 1'b0, 16'h0006);
        chk("ill_set", 32'(bus.illegal_op), 32'd1);
        step("legal", 1'b1, 1'b0, 16'h0000);
        chk("ill_sticky", 32'(bus.illegal_op), 32'd1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset("rnd_rst");
            else step("rnd", 1'($urandom), 1'($urandom), 16'($urandom));
        end
`ifdef IR_DECODE_PERF_EN
        do_reset("perf_rst");
        for (int i = 0; i < 3; i++) step("perf", 1'b1, 1'b0, 16'($urandom));
        chk("cnt3", 32'(bus.instr_count), 32'd3);
        while (m_cnt != 16'hFFFF) step("fill", 1'b1, 1'b0, 16'h0000);
        chk("cnt_max", 32'(bus.instr_count), 32'hFFFF);
        step("wrap", 1'b1, 1'b0, 16'h0000);
        chk("cnt_wrap", 32'(bus.instr_count), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_decode.md
Name: ir_decode

Overview:
- Instruction register (IR) plus memory data register (MDR) and field/immediate decode for the 16-bit multi-cycle core.
- Sits between unified memory read data and the Control FSM / register file / ALU muxes.
- Latches instructions on IRWrite and load data on MemR.
- Produces the registered 7-bit control word consumed by Control, register addresses, and a sign-extended immediate per instruction format.

Parameters:
- XLEN, 16, datapath and instruction width.
- RADDR_W, 3, register address width (8 registers).
- RESET_INSTR, 16'h0003, IR value loaded on reset; L-type, decodes to FETCH-return.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IRWrite  in  1  capture mem_rdata into IR at the next rising edge.
- MemR  in  1  capture mem_rdata into MDR at the next rising edge.
- mem_rdata  in  XLEN  memory read data; combinational from memory in the same cycle.
- control_word  out  7  {funct[3:0], opcode[2:0]} = IR[6:0]; drives Control input_control.
- rd_addr  out  RADDR_W  IR[9:7].
- rs1_addr  out  RADDR_W  IR[12:10].
- rs2_addr  out  RADDR_W  IR[15:13].
- imm_ext  out  XLEN  sign-extended immediate, combinational from IR.
- mdr  out  XLEN  MDR contents.
- ir_valid  out  1  IR holds an instruction captured since reset.
- illegal_op  out  1  sticky flag: an unsupported opcode was captured.

Behaviour:
- Reset (async, any cycle, including mid-instruction):
  - IR = RESET_INSTR, MDR = 0, ir_valid = 0, illegal_op = 0.
  - Outputs reflect these values immediately.
- IR capture:
  - On a rising edge with IRWrite=1, IR <= mem_rdata and ir_valid <= 1.
  - Otherwise IR holds; it must be stable across DECODE and every execute state.
  - Latency: control_word and fields update 1 cycle after IRWrite, i.e. valid in DECODE.
- MDR capture: on a rising edge with MemR=1, MDR <= mem_rdata; otherwise hold. The LW1 capture is visible in LW2.
- IRWrite and MemR both 1 in the same cycle: both registers load the same mem_rdata; no priority conflict.
- Opcode formats, opcode = IR[2:0], funct = IR[6:3]:
  - 000 3R: imm_ext = 0.
  - 001 2RI: imm_ext = sext(IR[15:13]), 3-bit. rs2_addr is still driven (branch compares use it).
  - 010 RI: imm_ext = sext(IR[15:10]), 6-bit.
  - 011 L: imm_ext = sext(IR[15:10]).
  - 100 UJ: imm_ext = sext(IR[15:7]), 9-bit.
  - 101/110/111: imm_ext = 0.
- Illegal opcode:
  - illegal_op sets at the capture edge when IRWrite=1 and mem_rdata[2:0] is 101, 110 or 111.
  - It stays set until Reset; later legal captures do not clear it.
- Sign extension is arithmetic: replicate the immediate MSB to bit 15. Examples: imm3 3'b100 -> 16'hFFFC; imm9 9'h0FF -> 16'h00FF.
- No combinational path from IRWrite or MemR to any output; all outputs are functions of registered state only.

Optional Feature:
- IR_DECODE_PERF_EN defined:
  - Adds output instr_count (out, 16), an instruction counter.
  - Resets to 0 and increments on each rising edge with IRWrite=1.
  - Wraps 16'hFFFF -> 0 with no saturation.
  - Reset has priority over an increment in the same cycle.
- Not defined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared package lime_pkg:
  - Opcode constants OP_3R=3'b000, OP_2RI=3'b001, OP_RI=3'b010, OP_L=3'b011, OP_UJ=3'b100.
  - XLEN and the register address width.
  - Field bit-position localparams.
- Control switches to the same opcode constants.
- One natural sub-module, imm_gen: purely combinational, IR in -> imm_ext out, reusable by a future branch-target unit.

Test Plan:
- Reset mid-run (IR previously 16'hABCD, illegal_op=1) -> immediately IR=16'h0003, ir_valid=0, illegal_op=0, mdr=0.
- IRWrite=1, mem_rdata=16'hE489 (2RI) -> next cycle control_word=7'h09, rd=1, rs1=1, rs2=7, imm_ext=16'hFFFF. Hold IRWrite=0 with mem_rdata changing for 3 cycles -> outputs unchanged.
- mem_rdata=16'h8002 (RI, IR[15:10]=6'b100000) -> imm_ext=16'hFFE0. mem_rdata=16'h7F84 (UJ, IR[15:7]=9'h0FF) -> imm_ext=16'h00FF.
- MemR=1, mem_rdata=16'h1234 for one cycle, then MemR=0, mem_rdata=16'h5555 -> mdr=16'h1234 from the next edge onward; IR unchanged.
- IRWrite with mem_rdata=16'h0006 (opcode 110) -> illegal_op=1. Subsequent legal capture 16'h0000 -> illegal_op remains 1.
- IR_DECODE_PERF_EN: 3 IRWrite pulses -> instr_count=3. Preload to 16'hFFFF, then one pulse -> 0.
